// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 keyboard types, FSM state codes and scan-code byte constants.
package ps2_pkg;
  typedef logic [2:0] state_e;
  localparam state_e S_IDLE = 3'd0;
  localparam state_e S_EXT = 3'd1;
  localparam state_e S_BRK = 3'd2;
  localparam state_e S_EXT_BRK = 3'd3;
  localparam state_e S_PAUSE = 3'd4;
  typedef struct packed {
    logic ext;
    logic rel;
    logic [7:0] code;
  } kbd_event_t;
  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;
  localparam logic [7:0] B_FA = 8'hFA;
  localparam logic [7:0] B_FE = 8'hFE;
  localparam logic [7:0] B_AA = 8'hAA;
  localparam logic [7:0] B_FC = 8'hFC;
  localparam logic [7:0] B_00 = 8'h00;
  localparam logic [7:0] B_FF = 8'hFF;
endpackage

// File: rtl/math.svh
// math.svh: shared constant-math helpers for elaboration-time parameters.
`ifndef MATH_SVH
`define MATH_SVH
`define CEIL(x) (($rtoi(x) < (x)) ? $rtoi(x) + 1 : $rtoi(x))
`endif

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with wrap-bit pointers, full/empty flags and head read from registered storage.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr = push && (!full || pop);
  assign rd = pop && !empty;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (rd) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: scan-code set 2 decoder feeding a key-event FIFO and device-reply pulses.
// Optional typematic repeat filter enabled by defining PS2_KBD_REPEAT_FILTER_EN.
`include "math.svh"
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter real FCLK_HZ = 50e6,
  parameter real PREFIX_TIMEOUT_S = 2e-3,
  parameter int  FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       ack_p,
  output logic       resend_p,
  output logic       bat_ok_p,
  output logic       bat_fail_p,
  output logic [2:0] err_flags,
  input  logic       err_clr
);
  localparam int TC = `CEIL(FCLK_HZ * PREFIX_TIMEOUT_S) - 1;
  localparam int CW = $clog2(TC + 1);
  localparam logic [CW-1:0] TC_V = CW'(TC);
  state_e state, state_n;
  logic [2:0] skip, skip_n;
  logic [CW-1:0] cnt;
  logic emit, keep, push_v, e2, tmo, ext_s, rel_s, full, empty, pop, ovf, idle_rx;
  kbd_event_t emit_d, push_d, head;
  assign tmo = state != S_IDLE && cnt == TC_V && !rx_valid;
  assign ext_s = state == S_EXT || state == S_EXT_BRK || rx_data == B_E0;
  assign rel_s = state == S_BRK || state == S_EXT_BRK || rx_data == B_F0;
  assign idle_rx = rx_valid && !rx_err && state == S_IDLE;
  always_comb begin
    state_n = state;
    skip_n = skip;
    emit = 1'b0;
    emit_d = '{ext: 1'b0, rel: 1'b0, code: rx_data};
    e2 = 1'b0;
    if (rx_valid && rx_err) state_n = S_IDLE;
    else if (rx_valid && state == S_IDLE) begin
      if (rx_data == B_E0) state_n = S_EXT;
      else if (rx_data == B_F0) state_n = S_BRK;
      else if (rx_data == B_E1) begin
        state_n = S_PAUSE;
        skip_n = 3'd7;
      end else if (rx_data == B_00 || rx_data == B_FF) e2 = 1'b1;
      else emit = !(rx_data == B_FA || rx_data == B_FE || rx_data == B_AA || rx_data == B_FC);
    end else if (rx_valid && state == S_PAUSE) begin
      skip_n = skip - 3'd1;
      emit = skip == 3'd1;
      emit_d.code = B_E1;
      state_n = skip == 3'd1 ? S_IDLE : S_PAUSE;
    end else if (rx_valid) begin
      // Prefix bytes inside a sequence accumulate rather than restart it
      if (rx_data == B_E0 || rx_data == B_F0) state_n = ext_s && rel_s ? S_EXT_BRK : ext_s ? S_EXT : S_BRK;
      else begin
        emit = 1'b1;
        emit_d.ext = ext_s;
        emit_d.rel = rel_s;
        state_n = S_IDLE;
      end
    end else if (tmo) state_n = S_IDLE;
  end
`ifdef PS2_KBD_REPEAT_FILTER_EN
  logic lm_v, lm_ext, lm_match;
  logic [7:0] lm_code;
  assign lm_match = lm_ext == emit_d.ext && lm_code == emit_d.code;
  assign keep = emit_d.rel || !(lm_v && lm_match);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lm_v <= 1'b0;
      lm_ext <= 1'b0;
      lm_code <= '0;
    end else if (rx_valid && rx_err) lm_v <= 1'b0;
    else if (emit && !emit_d.rel) begin
      lm_v <= 1'b1;
      lm_ext <= emit_d.ext;
      lm_code <= emit_d.code;
    end else if (emit && lm_match) lm_v <= 1'b0;
  end
`else
  assign keep = 1'b1;
`endif
  assign pop = ev_valid && ev_ready;
  assign ovf = push_v && full && !pop;
  assign ev_valid = !empty;
  assign {ev_ext, ev_rel, ev_code} = head;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      skip <= '0;
      cnt <= '0;
      push_v <= 1'b0;
      push_d <= '0;
      ack_p <= 1'b0;
      resend_p <= 1'b0;
      bat_ok_p <= 1'b0;
      bat_fail_p <= 1'b0;
      err_flags <= '0;
    end else begin
      state <= state_n;
      skip <= skip_n;
      cnt <= (rx_valid || state == S_IDLE) ? '0 : cnt + CW'(1);
      push_v <= emit && keep;
      push_d <= emit_d;
      ack_p <= idle_rx && rx_data == B_FA;
      resend_p <= idle_rx && rx_data == B_FE;
      bat_ok_p <= idle_rx && rx_data == B_AA;
      bat_fail_p <= idle_rx && rx_data == B_FC;
      err_flags <= (err_clr ? 3'b000 : err_flags) | {e2 || tmo, ovf, rx_valid && rx_err};
    end
  end
  sync_fifo #(.WIDTH(10), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push_v),
    .din(push_d),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed bench with a sequence-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_ps2_kbd_decoder;
  localparam int DEPTH = 8;
  localparam int TO_EDGES = 2000;
  logic clk = 0, rst = 1, rx_valid = 0, rx_err = 0, ev_ready = 1, err_clr = 0;
  logic [7:0] rx_data = 0;
  logic ev_valid, ev_ext, ev_rel, ack_p, resend_p, bat_ok_p, bat_fail_p;
  logic [7:0] ev_code;
  logic [2:0] err_flags;
  int checks = 0, errors = 0;
  logic [9:0] mq[$];
  logic [9:0] dlog[$];
  logic [9:0] nxt, tmp;
  logic nxt_v, inseq, m_ext, m_rel, lm_v, lm_ext;
  logic [7:0] lm_code;
  logic [2:0] m_err, set;
  logic [3:0] m_pulse;
  int pause_left, gap;
  always #5 clk = ~clk;
  ps2_kbd_decoder #(.FCLK_HZ(1e6), .PREFIX_TIMEOUT_S(2e-3), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel),
    .ack_p(ack_p), .resend_p(resend_p), .bat_ok_p(bat_ok_p), .bat_fail_p(bat_fail_p),
    .err_flags(err_flags), .err_clr(err_clr)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task m_emit(input logic e, input logic r, input logic [7:0] c);
    logic drop;
    drop = 0;
`ifdef PS2_KBD_REPEAT_FILTER_EN
    if (!r && lm_v && lm_ext == e && lm_code == c) drop = 1;
    else if (!r) begin lm_v = 1; lm_ext = e; lm_code = c; end
    else if (lm_ext == e && lm_code == c) lm_v = 0;
`endif
    if (!drop) begin nxt_v = 1; nxt = {e, r, c}; end
  endtask
  task m_clear_seq();
    inseq = 0; m_ext = 0; m_rel = 0; pause_left = 0; gap = 0;
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete(); m_err = 0; m_pulse = 0; nxt_v = 0; nxt = 0; lm_v = 0; lm_ext = 0; lm_code = 0;
      m_clear_seq();
    end else begin
      set = 0;
      m_pulse = 0;
      if (mq.size() > 0 && ev_ready) tmp = mq.pop_front();
      if (nxt_v) begin
        if (mq.size() < DEPTH) mq.push_back(nxt);
        else set[1] = 1;
      end
      nxt_v = 0;
      if (rx_valid && rx_err) begin
        set[0] = 1; lm_v = 0; m_clear_seq();
      end else if (rx_valid) begin
        gap = 0;
        if (pause_left > 0) begin
          pause_left--;
          if (pause_left == 0) m_emit(0, 0, 8'hE1);
        end else if (rx_data == 8'hE0) begin m_ext = 1; inseq = 1; end
        else if (rx_data == 8'hF0) begin m_rel = 1; inseq = 1; end
        else if (!inseq && rx_data == 8'hE1) pause_left = 7;
        else if (!inseq && rx_data == 8'hFA) m_pulse[0] = 1;
        else if (!inseq && rx_data == 8'hFE) m_pulse[1] = 1;
        else if (!inseq && rx_data == 8'hAA) m_pulse[2] = 1;
        else if (!inseq && rx_data == 8'hFC) m_pulse[3] = 1;
        else if (!inseq && (rx_data == 8'h00 || rx_data == 8'hFF)) set[2] = 1;
        else begin m_emit(m_ext, m_rel, rx_data); m_clear_seq(); end
      end else if (inseq || pause_left > 0) begin
        gap++;
        if (gap == TO_EDGES) begin set[2] = 1; m_clear_seq(); end
      end
      m_err = (err_clr ? 3'b000 : m_err) | set;
    end
  end
  always @(posedge clk) if (!rst && ev_valid && ev_ready) dlog.push_back({ev_ext, ev_rel, ev_code});
  always @(negedge clk) begin
    chk("ev_valid", 32'(ev_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("ev_word", 32'({ev_ext, ev_rel, ev_code}), 32'(mq[0]));
    chk("pulses", 32'({bat_fail_p, bat_ok_p, resend_p, ack_p}), 32'(m_pulse));
    chk("err_flags", 32'(err_flags), 32'(m_err));
  end
  task automatic send(input logic [7:0] b, input logic e = 0);
    @(negedge clk); rx_valid = 1; rx_data = b; rx_err = e;
    @(negedge clk); rx_valid = 0; rx_err = 0;
  endtask
  task automatic clr();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_code", 32'({ev_ext, ev_rel, ev_code}), 0);
    chk("rst_err", 32'(err_flags), 0);
    rst = 0;
    idle(2);
    dlog.delete();
    send(8'h1C);
    chk("lat_n1", 32'(ev_valid), 0);
    @(negedge clk);
    chk("lat_n2", 32'(ev_valid), 1);
    chk("lat_code", 32'({ev_ext, ev_rel, ev_code}), 32'h01C);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    idle(4);
    chk("ev_cnt", 32'(dlog.size()), 4);
    chk("ev_brk", 32'(dlog[1]), 32'h11C);
    chk("ev_ext", 32'(dlog[2]), 32'h275);
    chk("ev_extbrk", 32'(dlog[3]), 32'h375);
    dlog.delete();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    idle(4);
    chk("pause_cnt", 32'(dlog.size()), 1);
    chk("pause_ev", 32'(dlog[0]), 32'h0E1);
    dlog.delete();
    send(8'hFA); chk("ack", 32'(ack_p), 1);
    send(8'hFE); chk("resend", 32'(resend_p), 1);
    send(8'hAA); chk("bat_ok", 32'(bat_ok_p), 1);
    send(8'hFC); chk("bat_fail", 32'(bat_fail_p), 1);
    send(8'h00); chk("kbd_ovr", 32'(err_flags), 32'b100);
    idle(4);
    chk("reply_noev", 32'(dlog.size()), 0);
    clr();
    ev_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) send(8'(8'h10 + i));
    idle(2);
    chk("ovf_flag", 32'(err_flags[1]), 1);
    ev_ready = 1;
    idle(12);
    chk("ovf_cnt", 32'(dlog.size()), DEPTH);
    for (int i = 0; i < DEPTH; i++) chk("ovf_order", 32'(dlog[i]), 32'(8'h10 + i));
    clr();
    dlog.delete();
    ev_ready = 0;
    for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i));
    idle(3);
    send(8'h28);
    ev_ready = 1;
    @(negedge clk); ev_ready = 0;
    idle(2);
    chk("pushpop_noovf", 32'(err_flags[1]), 0);
    ev_ready = 1;
    idle(12);
    chk("pushpop_cnt", 32'(dlog.size()), DEPTH + 1);
    chk("pushpop_last", 32'(dlog[DEPTH]), 32'h028);
    dlog.delete();
    send(8'hE0);
    idle(1500);
    chk("tmo_early", 32'(err_flags[2]), 0);
    idle(600);
    chk("tmo_flag", 32'(err_flags[2]), 1);
    send(8'h1C);
    idle(4);
    chk("tmo_next", 32'(dlog[0]), 32'h01C);
    clr();
    dlog.delete();
    send(8'hF0);
    send(8'h55, 1);
    chk("rxerr_flag", 32'(err_flags[0]), 1);
    send(8'h1C);
    idle(4);
    chk("rxerr_cnt", 32'(dlog.size()), 1);
    chk("rxerr_next", 32'(dlog[0]), 32'h01C);
    dlog.delete();
    send(8'hE0);
    #3 rst = 1;
    #2 rst = 0;
    chk("arst_err", 32'(err_flags), 0);
    send(8'h2B);
    idle(4);
    chk("arst_next", 32'(dlog[0]), 32'h02B);
    dlog.delete();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    idle(4);
`ifdef PS2_KBD_REPEAT_FILTER_EN
    chk("rpt_cnt", 32'(dlog.size()), 3);
    chk("rpt_brk", 32'(dlog[1]), 32'h11C);
`else
    chk("rpt_cnt", 32'(dlog.size()), 5);
    chk("rpt_brk", 32'(dlog[3]), 32'h11C);
`endif
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
